// File: rtl/param_memory.sv
// Byte-enabled word memory with registered reads, range checking and a
// hardware zero-fill after reset. Optional read forwarding: MEM_FWD_EN.
module param_memory #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDR_W-1:0]   write_addr,
  input  logic [DATA_W-1:0]   datai,
  input  logic [DATA_W/8-1:0] be,
  input  logic                read,
  input  logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   datao,
  output logic                rvalid,
  output logic                err,
  output logic                busy
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_W:0]  LIMIT = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [IDX_W-1:0]  cnt;
  logic [IDX_W-1:0]  cnt_d;

  logic              clr_we;
  logic              run;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_hit;
  logic              rd_hit;
  logic              wr_en;
  logic              rd_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_old;
  logic [DATA_W-1:0] rd_fwd;
  logic [DATA_W-1:0] rd_word;

  assign wr_hit = {1'b0, write_addr} < LIMIT;
  assign rd_hit = {1'b0, addr} < LIMIT;
  assign wr_idx = write_addr[IDX_W-1:0];
  assign rd_idx = addr[IDX_W-1:0];
  assign wr_en  = run && we && wr_hit;
  assign rd_en  = run && read;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      CLEAR: begin
        cnt_d = cnt + IDX_W'(1);
        if (cnt == LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy   = (state == CLEAR);
    clr_we = (state == CLEAR);
    run    = (state == RUN);
  end

  // Storage carries no reset; the clear sequencer zero-fills it instead.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[wr_idx][8*i +: 8] <= datai[8*i +: 8];
        end
      end
    end
  end

  assign rd_old = mem[rd_idx];

  always_comb begin
    rd_fwd = rd_old;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) begin
        rd_fwd[8*i +: 8] = datai[8*i +: 8];
      end
    end
  end

`ifdef MEM_FWD_EN
  assign rd_word = (wr_en && (write_addr == addr))
                 ? rd_fwd : rd_old;
`else
  assign rd_word = rd_old;
`endif

  // Out-of-range reads still strobe rvalid, returning zero with err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      datao  <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      rvalid <= rd_en;
      err    <= run && ((we && !wr_hit) || (read && !rd_hit));
      if (rd_en) begin
        datao <= rd_hit ? rd_word : '0;
      end
    end
  end

endmodule
